irq_flag_unit: RTL and testbench

//  Interrupt-flag (IF, 0xFF0F) stage directly upstream of the SM83 core's CPU_IRQ_TRIG/CPU_IRQ_ACK pair.

---
 rtl/irq_flag_unit.sv | 92 +++++++++
 tb/tb_irq_flag_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_flag_unit.sv
// Interrupt-flag (IF) register stage feeding the SM83 core's IRQ trigger/acknowledge pair.
// Captures peripheral requests, serves IF over MMIO and stretches a STOP-mode wake pulse.
module irq_flag_unit #(
    parameter int unsigned          NUM_SRC   = 5,
    parameter logic [15:0]          IF_ADDR   = 16'hFF0F,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK = 5'b11111,
    parameter logic [NUM_SRC-1:0]   WAKE_MASK = 5'b10000,
    parameter int unsigned          WAKE_LEN  = 4
) (
    input  logic               CLK,
    input  logic               SYNC_RESET,
    input  logic [15:0]        A,
    input  logic [7:0]         D_in,
    output logic [7:0]         D_out,
    output logic               D_oe,
    input  logic               RD,
    input  logic               WR,
    input  logic               MMIO_REQ,
    input  logic [NUM_SRC-1:0] INT_SRC,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic [7:0]         CPU_IRQ_TRIG,
    output logic               WAKE
);

    localparam logic [3:0] WakeLoad = 4'(WAKE_LEN);

    logic [NUM_SRC-1:0] if_q, if_d;
    logic [NUM_SRC-1:0] src_prev_q;
    logic [3:0]         wake_cnt_q, wake_cnt_d;

    logic               sel;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] base;
    logic [7:0]         rd_val;
    logic               unused_bits;

    // Upper ACK/data bits carry no implemented source.
    assign unused_bits = ^{CPU_IRQ_ACK, D_in};

    assign sel = MMIO_REQ & (A == IF_ADDR);

    always_comb begin
        set = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            set[i] = EDGE_MASK[i] ? (INT_SRC[i] & ~src_prev_q[i]) : INT_SRC[i];
        end
    end

    // A new request always survives a same-cycle ACK or IF write of zero.
    always_comb begin
        base = (sel & WR) ? D_in[NUM_SRC-1:0] : if_q;
        if_d = (base & ~CPU_IRQ_ACK[NUM_SRC-1:0]) | set;
    end

    always_comb begin
        if (|(set & WAKE_MASK)) begin
            wake_cnt_d = WakeLoad;
        end else if (wake_cnt_q != 4'd0) begin
            wake_cnt_d = wake_cnt_q - 4'd1;
        end else begin
            wake_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RESET) begin
            if_q       <= '0;
            src_prev_q <= INT_SRC;
            wake_cnt_q <= 4'd0;
        end else begin
            if_q       <= if_d;
            src_prev_q <= INT_SRC;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Unimplemented IF bits read back as 1.
    always_comb begin
        rd_val              = 8'hFF;
        rd_val[NUM_SRC-1:0] = if_q;
    end

    always_comb begin
        CPU_IRQ_TRIG              = 8'h00;
        CPU_IRQ_TRIG[NUM_SRC-1:0] = if_q;
    end

    assign D_oe  = sel & RD;
    assign D_out = D_oe ? rd_val : 8'h00;
    assign WAKE  = (wake_cnt_q != 4'd0);

endmodule

// File: tb/tb_irq_flag_unit.sv
// Scoreboarded bench for irq_flag_unit: directed scenarios plus random traffic,
// checked against a behavioural model of the IF register and wake timer.
module tb_irq_flag_unit;

    logic        CLK = 1'b0;
    logic        SYNC_RESET = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic        MMIO_REQ = 1'b0;
    logic [4:0]  INT_SRC = 5'b00000;
    logic [7:0]  CPU_IRQ_ACK = 8'h00;
    logic [7:0]  CPU_IRQ_TRIG;
    logic        WAKE;

    irq_flag_unit dut (
        .CLK          (CLK),
        .SYNC_RESET   (SYNC_RESET),
        .A            (A),
        .D_in         (D_in),
        .D_out        (D_out),
        .D_oe         (D_oe),
        .RD           (RD),
        .WR           (WR),
        .MMIO_REQ     (MMIO_REQ),
        .INT_SRC      (INT_SRC),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .WAKE         (WAKE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        int         cyc;
        logic [7:0] trig;
        logic       wake;
        logic       oe;
        logic [7:0] dout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Behavioural model: IF contents, previous sources, remaining wake cycles.
    int m_if = 0;
    int m_prev = 0;
    int m_wake_left = 0;

    task automatic check(input string name, input int c, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%02h expected=%02h", name, c, got, exp);
        end
    endtask

    // One bus cycle: drive inputs, predict outputs for this cycle, then advance the model.
    task automatic step(input logic rst, input logic [15:0] a, input logic [7:0] din,
                        input logic rd, input logic wr, input logic mreq,
                        input logic [4:0] src, input logic [7:0] ack, input string tag);
        exp_t e;
        int   sel, set, base;
        @(negedge CLK);
        SYNC_RESET  = rst;
        A           = a;
        D_in        = din;
        RD          = rd;
        WR          = wr;
        MMIO_REQ    = mreq;
        INT_SRC     = src;
        CPU_IRQ_ACK = ack;
        cyc++;

        sel    = (mreq && a == 16'hFF0F) ? 1 : 0;
        e.tag  = tag;
        e.cyc  = cyc;
        e.trig = 8'(m_if);
        e.wake = (m_wake_left > 0);
        e.oe   = (sel != 0) && rd;
        e.dout = e.oe ? 8'(32'hE0 | m_if) : 8'h00;
        sb.push_back(e);

        if (rst) begin
            m_if        = 0;
            m_wake_left = 0;
        end else begin
            set  = int'(src) & ~m_prev & 32'h1F;
            base = (sel != 0 && wr) ? (int'(din) & 32'h1F) : m_if;
            m_if = (base & ~int'(ack)) & 32'h1F | set;
            if ((set & 32'h10) != 0) m_wake_left = 4;
            else if (m_wake_left > 0) m_wake_left--;
        end
        m_prev = int'(src);
    endtask

    task automatic idle(input logic [4:0] src, input string tag);
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, src, 8'h00, tag);
    endtask

    task automatic wr_if(input logic [7:0] v, input logic [4:0] src, input string tag);
        step(1'b0, 16'hFF0F, v, 1'b0, 1'b1, 1'b1, src, 8'h00, tag);
    endtask

    task automatic rd_at(input logic [15:0] a, input logic [4:0] src, input string tag);
        step(1'b0, a, 8'h00, 1'b1, 1'b0, 1'b1, src, 8'h00, tag);
    endtask

    // Monitor: outputs are settled 2 time units after the driving negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_trig"}, e.cyc, CPU_IRQ_TRIG, e.trig);
                check({e.tag, "_wake"}, e.cyc, {7'd0, WAKE}, {7'd0, e.wake});
                check({e.tag, "_oe"}, e.cyc, {7'd0, D_oe}, {7'd0, e.oe});
                check({e.tag, "_dout"}, e.cyc, D_out, e.dout);
            end
        end
    end

    initial begin
        logic [4:0]  src;
        logic [15:0] a;
        logic [7:0]  ack;
        int          r;

        // 1: reset with Timer held high; release must not see an edge.
        step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 5'b00100, 8'h00, "t1_rst");
        step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 5'b00100, 8'h00, "t1_rst");
        repeat (4) idle(5'b00100, "t1_hold");
        idle(5'b00000, "t1_low");

        // 2: VBlank edge then ACK.
        idle(5'b00001, "t2_edge");
        idle(5'b00000, "t2_trig");
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 5'b00000, 8'h01, "t2_ack");
        idle(5'b00000, "t2_clear");

        // 3: Timer edge beats a same-cycle ACK; STAT edge beats a write of zero.
        idle(5'b00100, "t3_set");
        idle(5'b00000, "t3_pend");
        step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 5'b00100, 8'h04, "t3_ackset");
        idle(5'b00000, "t3_kept");
        step(1'b0, 16'hFF0F, 8'h00, 1'b0, 1'b1, 1'b1, 5'b00010, 8'h00, "t3_wrset");
        rd_at(16'hFF0F, 5'b00000, "t3_rd");

        // 4: register writes and reads, including a near-miss address.
        wr_if(8'hFF, 5'b00000, "t4_wff");
        rd_at(16'hFF0F, 5'b00000, "t4_rff");
        wr_if(8'h05, 5'b00000, "t4_w05");
        rd_at(16'hFF0F, 5'b00000, "t4_r05");
        rd_at(16'hFF0E, 5'b00000, "t4_rmiss");
        step(1'b0, 16'hFF0F, 8'h00, 1'b1, 1'b0, 1'b0, 5'b00000, 8'h00, "t4_nomreq");
        wr_if(8'h00, 5'b00000, "t4_w00");

        // 5: Joypad wake pulse, retrigger, and VBlank not waking.
        idle(5'b10000, "t5_joy");
        idle(5'b10000, "t5_w1");
        idle(5'b00000, "t5_w2");
        idle(5'b10000, "t5_retrig");
        repeat (6) idle(5'b10000, "t5_tail");
        idle(5'b10001, "t5_vblank");
        repeat (3) idle(5'b10001, "t5_nowake");
        wr_if(8'h00, 5'b00000, "t5_clr");

        // 6: reset in the middle of a wake pulse with all flags pending.
        wr_if(8'hFF, 5'b00000, "t6_wff");
        idle(5'b10000, "t6_joy");
        idle(5'b10000, "t6_wake");
        step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 5'b10000, 8'h00, "t6_rst");
        repeat (3) idle(5'b10000, "t6_after");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            src = 5'($urandom);
            if ($urandom_range(3) != 0) src[4] = INT_SRC[4];
            r = $urandom_range(3);
            a = (r == 0) ? 16'hFF0E : (r == 3) ? 16'($urandom) : 16'hFF0F;
            r = $urandom_range(3);
            ack = (r == 0) ? 8'(1 << $urandom_range(4)) : (r == 1) ? 8'($urandom) : 8'h00;
            step(($urandom_range(49) == 0), a, 8'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), src, ack, "rnd");
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLK);
        @(negedge CLK);
        #3;
        check("sb_drain", cyc, 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
